// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_pkg
//  Description : Shared types for the instruction fetch queue: FSM state
//                encoding, PC increment and queue entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } if_state_t;

    localparam int PC_STEP = 4;

    localparam int NB_ENTRY_FIELD = 32;

    // Queue entries are packed {pc, instr}; the top uses the same field order.
    typedef struct packed {
        logic [NB_ENTRY_FIELD-1:0] pc;
        logic [NB_ENTRY_FIELD-1:0] instr;
    } if_entry_t;

endpackage
`default_nettype wire

// File: rtl/if_prefetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : if_prefetch_fifo
//  Description : DEPTH-entry FIFO with registered head, synchronous flush and
//                push-while-full when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_full
);

    localparam int               c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic [WIDTH-1:0]   r_head;

    logic               w_do_pop;
    logic               w_do_push;
    logic [c_PTR_W-1:0] w_rd_next;
    logic [c_PTR_W:0]   w_left;
    logic [WIDTH-1:0]   w_head_next;

    assign o_valid   = (r_count != '0);
    assign o_full    = (r_count == c_FULL);
    assign o_data    = r_head;

    assign w_do_pop  = i_pop && o_valid && !i_flush;
    assign w_do_push = i_push && (!o_full || w_do_pop) && !i_flush;
    assign w_rd_next = r_rd_ptr + c_PTR_W'(w_do_pop);
    assign w_left    = r_count - (c_PTR_W+1)'(w_do_pop);

    // Head register holds its last value once the queue drains.
    always_comb begin
        w_head_next = r_head;
        if (w_left != '0) begin
            w_head_next = r_mem[w_rd_next];
        end else if (w_do_push) begin
            w_head_next = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_do_push);
            r_rd_ptr <= w_rd_next;
            r_count  <= w_left + (c_PTR_W+1)'(w_do_push);
            r_head   <= w_head_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/xilinx_one_port_ram_async.sv
`default_nettype none
// ============================================================================
//  Module      : xilinx_one_port_ram_async
//  Description : Single-port RAM, synchronous write, asynchronous read.
//  Revision    : 1.0 - initial release
// ============================================================================
module xilinx_one_port_ram_async #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic [DATA_WIDTH-1:0] o_dout
);

    logic [DATA_WIDTH-1:0] r_ram [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_ram[i_addr] <= i_din;
        end
    end

    assign o_dout = r_ram[i_addr];

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_queue
//  Description : PC, instruction RAM and prefetch queue between the program
//                loader and decode. Optional macro IF_PERF_CNT_EN adds
//                fetch/flush performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_queue
    import if_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 8,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_load_addr,
    input  logic [NB_DATA-1:0] i_instr_data,
    input  logic               i_start,
    input  logic               i_jump,
    input  logic [NB_DATA-1:0] i_addr2jump,
    input  logic               i_halt,
    input  logic               i_ready,
    output logic               o_valid,
    output logic [NB_DATA-1:0] o_instruction,
    output logic [NB_DATA-1:0] o_pcounter,
    output logic [NB_DATA-1:0] o_pcounter4,
    output logic               o_halted,
    output logic [1:0]         o_state
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        o_fetch_cnt,
    output logic [31:0]        o_flush_cnt
`endif
);

    if_state_t          r_state;
    logic [NB_DATA-1:0] r_pc;

    logic               w_run;
    logic               w_jump;
    logic               w_pop;
    logic               w_push;
    logic               w_full;
    logic               w_ram_we;
    logic [NB_ADDR-1:0] w_ram_addr;
    logic [NB_DATA-1:0] w_ram_dout;
    logic [2*NB_DATA-1:0] w_head;

    assign w_run  = (r_state == RUN);
    // Halt takes priority over a simultaneous jump.
    assign w_jump = w_run && i_jump && !i_halt;
    assign w_pop  = o_valid && i_ready && !w_jump;
    assign w_push = w_run && !i_halt && !w_jump && (!w_full || w_pop);

    assign w_ram_we   = i_we && (r_state == LOAD);
    assign w_ram_addr = (r_state == LOAD) ? i_load_addr : r_pc[NB_ADDR+1:2];

    xilinx_one_port_ram_async #(
        .ADDR_WIDTH (NB_ADDR),
        .DATA_WIDTH (NB_DATA)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_din  (i_instr_data),
        .o_dout (w_ram_dout)
    );

    if_prefetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*NB_DATA)
    ) u_fifo (
        .clk     (clk),
        .i_rst   (i_rst),
        .i_flush (w_jump),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({r_pc, w_ram_dout}),
        .o_data  (w_head),
        .o_valid (o_valid),
        .o_full  (w_full)
    );

    assign o_pcounter    = w_head[2*NB_DATA-1:NB_DATA];
    assign o_instruction = w_head[NB_DATA-1:0];
    assign o_pcounter4   = o_pcounter + NB_DATA'(PC_STEP);
    assign o_halted      = (r_state == HALT) && !o_valid;
    assign o_state       = r_state;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= LOAD;
        end else begin
            case (r_state)
                LOAD:    if (i_start) r_state <= RUN;
                RUN:     if (i_halt)  r_state <= HALT;
                HALT:    r_state <= HALT;
                default: r_state <= LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_pc <= '0;
        end else if (w_jump) begin
            r_pc <= i_addr2jump;
        end else if (w_push) begin
            r_pc <= r_pc + NB_DATA'(PC_STEP);
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_push) r_fetch_cnt <= r_fetch_cnt + 32'd1;
            // Only flushes that actually discard queued work are counted.
            if (w_jump && o_valid) r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign o_fetch_cnt = r_fetch_cnt;
    assign o_flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire
